secure_scan_register: RTL and testbench
=======================================

Name: secure_scan_register

Overview:
- Parametrised IJTAG test data register (TDR) with capture/shift/update and a shadow update register.
- Its update stage is key-authenticated: the shadow output changes only when the shifted-in key field matches the parameter KEY.
- Repeated wrong keys drive a saturating failure counter; once the counter saturates, the register locks until reset.
- Sits inside a scan segment between the segment insertion logic and instrument control inputs; chains serially through SI/SO.

Parameters:
- WIDTH, 8, number of data bits delivered to the instrument (ParOut/ParIn width).
- KEY_W, 4, number of key bits appended above the data field in the shift path.
- KEY, 4'hA, expected key value (KEY_W bits).
- MAX_FAIL, 3, number of failed updates that cause the lock (1..255).
- RESET_VAL, 0, value of ParOut after reset (WIDTH bits).

Ports:
- CLK  input  1  scan clock; all state changes on its rising edge.
- Rst  input  1  synchronous active-high reset.
- Sel  input  1  register selected by the segment; all operations are ignored when 0.
- CaptureEn  input  1  capture request.
- ShiftEn  input  1  shift request.
- UpdateEn  input  1  update request.
- SI  input  1  serial scan in.
- SO  output  1  serial scan out.
- ParIn  input  WIDTH  instrument status, captured into the data field.
- ParOut  output  WIDTH  shadow register driving the instrument.
- AuthFail  output  1  one-cycle pulse on a rejected update.
- Locked  output  1  high once the failure count reaches MAX_FAIL.

Behaviour:
- Internal shift register sr is WIDTH+KEY_W bits.
  - Data field: sr[WIDTH-1:0].
  - Key field: sr[WIDTH+KEY_W-1:WIDTH].
- Fail counter fc is 8 bits and saturates at MAX_FAIL.
- Reset (Rst=1 at a clock edge), which overrides everything:
  - sr <= 0, ParOut <= RESET_VAL, fc <= 0, Locked <= 0, AuthFail <= 0.
- SO = sr[0] combinationally; SO is 0 after reset.
- When Sel=0, sr, ParOut and fc hold, and AuthFail is 0.
- When Sel=1, exactly one operation occurs per cycle, with priority Capture > Shift > Update:
  - Capture:
    - Data field <= ParIn.
    - Key field <= 0, so the key is never readable on SO.
  - Shift:
    - sr <= {SI, sr[WIDTH+KEY_W-1:1]}.
    - The first bit shifted in lands in sr[0] after WIDTH+KEY_W shifts.
    - Serial order is data LSB first, then key LSB first.
  - Update with the key field equal to KEY and Locked=0:
    - ParOut <= data field on the same edge, so ParOut is visible in the next cycle.
    - fc is unchanged.
    - AuthFail <= 0.
  - Update with the key field not equal to KEY, or with Locked=1:
    - ParOut holds.
    - AuthFail <= 1 for exactly one cycle.
    - fc <= min(fc+1, MAX_FAIL).
  - Locked is a flop: Locked <= (next fc == MAX_FAIL). It stays 1 until Rst, and a correct key does not clear it.
- AuthFail is 0 in every cycle not immediately following a rejected update. Back-to-back rejected updates hold it high for consecutive cycles.
- Capture or shift never modify ParOut, fc or Locked.
- The key field is cleared on capture only, not on update. A second update without re-shifting reuses the same key and data.
- Reset asserted mid-shift discards all partial scan content. No state survives reset.
- KEY_W=0 is not supported (minimum is 1).

Test Plan (WIDTH=8, KEY_W=4, KEY=4'hA, MAX_FAIL=3, RESET_VAL=8'h00):
- Reset:
  - Stimulus: Rst=1 for 2 cycles with random other inputs.
  - Response: ParOut=8'h00, SO=0, AuthFail=0, Locked=0.
- Authenticated write:
  - Stimulus: Sel=1; shift 12 bits encoding data 8'h5C and key 4'hA; then one UpdateEn cycle.
  - Response: ParOut=8'h5C in the next cycle, AuthFail stays 0.
- Capture and readback:
  - Stimulus: ParIn=8'h3E; Capture; then 12 shifts with SI=0.
  - Response: SO sequence is 0,1,1,1,1,1,0,0 (LSB first), followed by 0,0,0,0 for the key field.
- Wrong key:
  - Stimulus: shift data 8'hFF with key 4'h5; UpdateEn.
  - Response: ParOut unchanged (8'h5C), AuthFail high for 1 cycle, Locked=0.
- Lockout:
  - Stimulus: three wrong-key updates, then a correct key with data 8'h11 and UpdateEn.
  - Response: Locked=1 after the third failure. The correct-key update is rejected: ParOut holds and AuthFail pulses. After Rst, the correct key writes 8'h11.
- Deselect and priority:
  - Stimulus: Sel=0 with ShiftEn/UpdateEn toggling; then Sel=1 with CaptureEn=ShiftEn=UpdateEn=1 and ParIn=8'hA5.
  - Response: with Sel=0 there are no state changes. With all enables set, only capture occurs: data field = 8'hA5, ParOut unchanged.

Source files
------------

// File: rtl/secure_scan_register.sv
// secure_scan_register: IJTAG test data register with a key-authenticated shadow update stage.
// Ports:
//   CLK, Rst                  scan clock, synchronous active-high reset
//   Sel                       segment select; all operations are ignored when low
//   CaptureEn/ShiftEn/UpdateEn  operation requests, priority capture > shift > update
//   SI, SO                    serial scan in / out (SO is the shift register LSB)
//   ParIn, ParOut             instrument status in / shadow register out
//   AuthFail                  one-cycle pulse after a rejected update
//   Locked                    set once MAX_FAIL updates have been rejected, cleared only by Rst
module secure_scan_register #(
    parameter int                WIDTH     = 8,
    parameter int                KEY_W     = 4,
    parameter logic [KEY_W-1:0]  KEY       = 4'hA,
    parameter int                MAX_FAIL  = 3,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             Rst,
    input  logic             Sel,
    input  logic             CaptureEn,
    input  logic             ShiftEn,
    input  logic             UpdateEn,
    input  logic             SI,
    output logic             SO,
    input  logic [WIDTH-1:0] ParIn,
    output logic [WIDTH-1:0] ParOut,
    output logic             AuthFail,
    output logic             Locked
);
    localparam int N = WIDTH + KEY_W;
    localparam logic [7:0] MF = 8'(MAX_FAIL);

    logic [N-1:0]     sr_q, sr_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic [7:0]       fc_q, fc_d;
    logic             fail_q, fail_d;
    logic             lock_q, lock_d;
    logic             cap, sh, up, ok;

    assign cap = Sel && CaptureEn;
    assign sh  = Sel && ShiftEn && !CaptureEn;
    assign up  = Sel && UpdateEn && !CaptureEn && !ShiftEn;
    // Lock overrides even a correct key.
    assign ok  = (sr_q[N-1:WIDTH] == KEY) && !lock_q;

    always_comb begin
        sr_d   = cap ? {{KEY_W{1'b0}}, ParIn} : sh ? {SI, sr_q[N-1:1]} : sr_q;
        par_d  = (up && ok) ? sr_q[WIDTH-1:0] : par_q;
        fail_d = up && !ok;
        fc_d   = !fail_d ? fc_q : (fc_q >= MF) ? MF : fc_q + 8'd1;
        lock_d = (fc_d == MF);
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            sr_q   <= '0;
            par_q  <= RESET_VAL;
            fc_q   <= '0;
            fail_q <= 1'b0;
            lock_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            par_q  <= par_d;
            fc_q   <= fc_d;
            fail_q <= fail_d;
            lock_q <= lock_d;
        end
    end

    assign SO       = sr_q[0];
    assign ParOut   = par_q;
    assign AuthFail = fail_q;
    assign Locked   = lock_q;
endmodule

// File: tb/tb_secure_scan_register.sv
// tb_secure_scan_register: directed self-checking bench for secure_scan_register.
module tb_secure_scan_register;
    logic       CLK = 1'b0;
    logic       Rst, Sel, CaptureEn, ShiftEn, UpdateEn, SI;
    logic       SO, AuthFail, Locked;
    logic [7:0] ParIn, ParOut;
    int         n_chk = 0;
    int         n_fail = 0;

    secure_scan_register #(
        .WIDTH(8), .KEY_W(4), .KEY(4'hA), .MAX_FAIL(3), .RESET_VAL(8'h00)
    ) dut (
        .CLK(CLK), .Rst(Rst), .Sel(Sel), .CaptureEn(CaptureEn), .ShiftEn(ShiftEn),
        .UpdateEn(UpdateEn), .SI(SI), .SO(SO), .ParIn(ParIn), .ParOut(ParOut),
        .AuthFail(AuthFail), .Locked(Locked)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic shift_in(input logic [7:0] d, input logic [3:0] k);
        logic [11:0] v;
        v = {k, d};
        ShiftEn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            SI = v[i];
            tick();
        end
        ShiftEn = 1'b0;
        SI = 1'b0;
    endtask

    task automatic update();
        UpdateEn = 1'b1;
        tick();
        UpdateEn = 1'b0;
    endtask

    task automatic shift_out(input string tag, input logic [11:0] exp);
        ShiftEn = 1'b1;
        SI = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), {31'b0, SO}, {31'b0, exp[i]});
            tick();
        end
        ShiftEn = 1'b0;
    endtask

    initial begin
        // Reset with random other inputs
        Rst = 1'b1;
        Sel = 1'($urandom); CaptureEn = 1'($urandom); ShiftEn = 1'($urandom);
        UpdateEn = 1'($urandom); SI = 1'($urandom); ParIn = 8'($urandom);
        tick();
        Sel = 1'($urandom); CaptureEn = 1'($urandom); ShiftEn = 1'($urandom);
        UpdateEn = 1'($urandom); SI = 1'($urandom); ParIn = 8'($urandom);
        tick();
        Rst = 1'b0; Sel = 1'b0; CaptureEn = 1'b0; ShiftEn = 1'b0;
        UpdateEn = 1'b0; SI = 1'b0; ParIn = 8'h00;
        #1;
        chk("rst_parout", ParOut, 8'h00);
        chk("rst_so", SO, 0);
        chk("rst_authfail", AuthFail, 0);
        chk("rst_locked", Locked, 0);

        // Authenticated write
        Sel = 1'b1;
        shift_in(8'h5C, 4'hA);
        chk("auth_so_after_shift", SO, 0);
        chk("auth_parout_before", ParOut, 8'h00);
        update();
        chk("auth_parout", ParOut, 8'h5C);
        chk("auth_authfail", AuthFail, 0);
        tick();
        chk("auth_parout_hold", ParOut, 8'h5C);

        // Capture and readback, key field reads as zero
        ParIn = 8'h3E;
        CaptureEn = 1'b1;
        tick();
        CaptureEn = 1'b0;
        chk("cap_parout", ParOut, 8'h5C);
        shift_out("cap_read", 12'h03E);

        // Wrong key
        shift_in(8'hFF, 4'h5);
        update();
        chk("wk_parout", ParOut, 8'h5C);
        chk("wk_authfail", AuthFail, 1);
        chk("wk_locked", Locked, 0);
        tick();
        chk("wk_authfail_clear", AuthFail, 0);

        // Lockout: back-to-back rejected updates reusing the wrong key
        UpdateEn = 1'b1;
        tick();
        chk("lk_fail2_authfail", AuthFail, 1);
        chk("lk_fail2_locked", Locked, 0);
        tick();
        chk("lk_fail3_authfail", AuthFail, 1);
        chk("lk_fail3_locked", Locked, 1);
        tick();
        chk("lk_fail4_authfail", AuthFail, 1);
        chk("lk_fail4_locked", Locked, 1);
        UpdateEn = 1'b0;
        tick();
        chk("lk_authfail_clear", AuthFail, 0);
        shift_in(8'h11, 4'hA);
        chk("lk_locked_after_shift", Locked, 1);
        update();
        chk("lk_good_rejected_parout", ParOut, 8'h5C);
        chk("lk_good_rejected_authfail", AuthFail, 1);
        chk("lk_still_locked", Locked, 1);

        // Reset mid-shift discards everything
        ShiftEn = 1'b1; SI = 1'b1;
        tick(); tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0; ShiftEn = 1'b0; SI = 1'b0;
        #1;
        chk("rst2_parout", ParOut, 8'h00);
        chk("rst2_locked", Locked, 0);
        chk("rst2_so", SO, 0);
        chk("rst2_authfail", AuthFail, 0);
        shift_in(8'h11, 4'hA);
        update();
        chk("post_rst_parout", ParOut, 8'h11);
        chk("post_rst_authfail", AuthFail, 0);
        update();
        chk("reuse_parout", ParOut, 8'h11);
        chk("reuse_authfail", AuthFail, 0);

        // Deselect: nothing changes
        Sel = 1'b0;
        chk("desel_so_before", SO, 1);
        for (int i = 0; i < 4; i++) begin
            ShiftEn = 1'b1; UpdateEn = i[0]; CaptureEn = i[1]; SI = 1'b0; ParIn = 8'h00;
            tick();
            chk($sformatf("desel_so_%0d", i), SO, 1);
            chk($sformatf("desel_authfail_%0d", i), AuthFail, 0);
        end
        ShiftEn = 1'b0; UpdateEn = 1'b0; CaptureEn = 1'b0;
        chk("desel_parout", ParOut, 8'h11);

        // Priority: capture wins over shift and update
        Sel = 1'b1; ParIn = 8'hA5; SI = 1'b0;
        CaptureEn = 1'b1; ShiftEn = 1'b1; UpdateEn = 1'b1;
        tick();
        CaptureEn = 1'b0; ShiftEn = 1'b0; UpdateEn = 1'b0;
        chk("prio_parout", ParOut, 8'h11);
        chk("prio_authfail", AuthFail, 0);
        chk("prio_locked", Locked, 0);
        shift_out("prio_read", 12'h0A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
